// File: rtl/backtrack_stack.sv
// backtrack_stack: LIFO frame store and result accumulator for the return path
// of the 2/3-multiplier recursion. Frames {n, twothree} are pushed while
// descending; a backtrack seeds the accumulator and unwinds the stack, scaling
// the accumulator by 2 (twothree=1) or 3 (twothree=0) for every popped frame.
//
// Optional feature macro: STACK_ERR_FLAG_EN
//   defined   -> err is a sticky flag raised by a push into a full stack or a
//                backtrack on an empty stack (cleared only by rst)
//   undefined -> err is tied low
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | accepting push/backtrack, ready=1
// POP   | remove top frame, latch it onto n_top/tt_top
// MUL   | scale acc by the latched frame's factor; loop or finish
// FIN   | final_done pulse for one cycle, then back to IDLE
module backtrack_stack #(
    parameter int size  = 4,
    parameter int DEPTH = 8,
    parameter int ACC_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [size-1:0]          n_in,
    input  logic                     tt_in,
    input  logic                     backtrack,
    input  logic [ACC_W-1:0]         base_val,
    output logic                     ready,
    output logic [size-1:0]          n_top,
    output logic                     tt_top,
    output logic [ACC_W-1:0]         result,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     final_done,
    output logic                     err
);

    localparam int AW  = $clog2(DEPTH);
    localparam int SPW = AW + 1;
    localparam logic [SPW-1:0] SP_ONE  = SPW'(1);
    localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_POP  = 2'd1,
        S_MUL  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [size:0]      r_mem [DEPTH];
    logic [SPW-1:0]     r_sp;
    logic [ACC_W-1:0]   r_acc;
    logic [size-1:0]    r_n_top;
    logic               r_tt_top;

    logic               w_full;
    logic               w_empty;
    logic               w_idle;
    logic               w_do_push;
    logic               w_load;
    logic [SPW-1:0]     w_sp_m1;
    logic [ACC_W-1:0]   w_acc_x2;
    logic [ACC_W-1:0]   w_acc_x3;

    assign w_full    = (r_sp == SP_FULL);
    assign w_empty   = (r_sp == '0);
    assign w_idle    = (r_state == S_IDLE);
    // backtrack wins over a same-cycle push; a push into a full stack is dropped
    assign w_do_push = w_idle && push && !backtrack && !w_full;
    assign w_load    = w_idle && backtrack;
    assign w_sp_m1   = r_sp - SP_ONE;
    // x2 and x3 built from shift/add; the carry-out is discarded (mod 2^ACC_W)
    assign w_acc_x2  = {r_acc[ACC_W-2:0], 1'b0};
    assign w_acc_x3  = w_acc_x2 + r_acc;

    // next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (backtrack) begin
                    w_next = w_empty ? S_FIN : S_POP;
                end
            end
            S_POP:   w_next = S_MUL;
            S_MUL:   w_next = w_empty ? S_FIN : S_POP;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // stack pointer, popped-frame latch and accumulator
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sp     <= '0;
            r_acc    <= '0;
            r_n_top  <= '0;
            r_tt_top <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_sp <= r_sp + SP_ONE;
            end
            if (w_load) begin
                r_acc <= base_val;
            end
            if (r_state == S_POP) begin
                r_sp                <= w_sp_m1;
                {r_n_top, r_tt_top} <= r_mem[w_sp_m1[AW-1:0]];
            end
            if (r_state == S_MUL) begin
                r_acc <= r_tt_top ? w_acc_x2 : w_acc_x3;
            end
        end
    end

    // frame memory; contents survive reset, only the pointer is cleared
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_sp[AW-1:0]] <= {n_in, tt_in};
        end
    end

`ifdef STACK_ERR_FLAG_EN
    logic r_err;

    // sticky misuse flag: push into full stack or backtrack on empty stack
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_idle && ((push && !backtrack && w_full) || (backtrack && w_empty))) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign ready      = w_idle;
    assign n_top      = r_n_top;
    assign tt_top     = r_tt_top;
    assign result     = r_acc;
    assign count      = r_sp;
    assign full       = w_full;
    assign empty      = w_empty;
    assign final_done = (r_state == S_FIN);

endmodule

// File: tb/tb_backtrack_stack.sv
// Testbench for backtrack_stack: randomized push/backtrack traffic against a
// queue-based reference model, with a scoreboard monitor that checks every
// final_done pulse.
module tb_backtrack_stack;

    localparam int SIZE  = 4;
    localparam int DEPTH = 8;
    localparam int ACC_W = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              push;
    logic [SIZE-1:0]   n_in;
    logic              tt_in;
    logic              backtrack;
    logic [ACC_W-1:0]  base_val;
    logic              ready;
    logic [SIZE-1:0]   n_top;
    logic              tt_top;
    logic [ACC_W-1:0]  result;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;
    logic              final_done;
    logic              err;

    backtrack_stack #(.size(SIZE), .DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .push(push), .n_in(n_in), .tt_in(tt_in),
        .backtrack(backtrack), .base_val(base_val), .ready(ready),
        .n_top(n_top), .tt_top(tt_top), .result(result), .count(count),
        .full(full), .empty(empty), .final_done(final_done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int n;
        int tt;
    } frame_t;

    typedef struct {
        int res;
        int n;
        int tt;
        int t0;
        int lat;
    } exp_t;

    frame_t mdl_q[$];
    exp_t   sb[$];
    int     mdl_n   = 0;
    int     mdl_tt  = 0;
    int     mdl_err = 0;
    int     checks  = 0;
    int     errors  = 0;

`ifdef STACK_ERR_FLAG_EN
    localparam int ERR_EN = 1;
`else
    localparam int ERR_EN = 0;
`endif

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // scoreboard monitor: every final_done must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && final_done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_final_done actual=1 expected=0 (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", int'(result), e.res);
                chk("latency", cyc - e.t0, e.lat);
                chk("n_top_last", int'(n_top), e.n);
                chk("tt_top_last", int'(tt_top), e.tt);
                chk("empty_at_done", int'(empty), 1);
            end
        end
    end

    task automatic do_push(input int n, input int tt);
        push  = 1'b1;
        n_in  = SIZE'(n);
        tt_in = tt[0];
        if (mdl_q.size() < DEPTH) begin
            frame_t f;
            f.n  = n;
            f.tt = tt;
            mdl_q.push_back(f);
        end else begin
            mdl_err = ERR_EN;
        end
        @(posedge clk);
        #1 push = 1'b0;
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!ready && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout actual=0 expected=1 (t=%0t)", $time);
        end
    endtask

    // backtrack: model computes result by folding frames from top to bottom
    task automatic do_backtrack(input int base, input bit with_push);
        exp_t e;
        int   k;
        int   acc;
        k   = mdl_q.size();
        acc = base;
        for (int i = k - 1; i >= 0; i--) begin
            acc = (acc * ((mdl_q[i].tt != 0) ? 2 : 3)) % 256;
        end
        if (k > 0) begin
            mdl_n  = mdl_q[0].n;
            mdl_tt = mdl_q[0].tt;
        end else begin
            mdl_err = ERR_EN;
        end
        e.res = acc;
        e.n   = mdl_n;
        e.tt  = mdl_tt;
        e.t0  = cyc;
        e.lat = 2 * k + 1;
        sb.push_back(e);
        mdl_q.delete();
        backtrack = 1'b1;
        base_val  = ACC_W'(base);
        push      = with_push;
        n_in      = SIZE'($urandom_range(0, 15));
        tt_in     = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        backtrack = 1'b0;
        push      = 1'b0;
        @(negedge clk);
        wait_ready();
        chk("count_after_bt", int'(count), 0);
        chk("result_hold", int'(result), acc);
        chk("err_after_bt", int'(err), mdl_err);
    endtask

    task automatic check_occupancy(input string tag);
        @(negedge clk);
        chk({tag, "_count"}, int'(count), mdl_q.size());
        chk({tag, "_full"}, int'(full), int'(mdl_q.size() == DEPTH));
        chk({tag, "_empty"}, int'(empty), int'(mdl_q.size() == 0));
        chk({tag, "_err"}, int'(err), mdl_err);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mdl_q.delete();
        mdl_n   = 0;
        mdl_tt  = 0;
        mdl_err = 0;
    endtask

    initial begin
        rst       = 1'b1;
        push      = 1'b0;
        n_in      = '0;
        tt_in     = 1'b0;
        backtrack = 1'b0;
        base_val  = '0;

        // reset state
        do_reset();
        @(negedge clk);
        chk("rst_ready", int'(ready), 1);
        chk("rst_empty", int'(empty), 1);
        chk("rst_count", int'(count), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_final_done", int'(final_done), 0);
        chk("rst_full", int'(full), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_n_top", int'(n_top), 0);

        // three frames, base 1 -> 12
        do_push(3, 1);
        do_push(5, 0);
        do_push(7, 1);
        check_occupancy("three");
        do_backtrack(1, 1'b0);
        chk("three_result_const", int'(result), 12);
        chk("three_n_top_const", int'(n_top), 3);

        // fill and overflow
        for (int i = 0; i < DEPTH; i++) do_push(i + 1, i % 2);
        do_push(15, 1);
        check_occupancy("overflow");
        chk("overflow_full_const", int'(full), 1);
        do_backtrack(5, 1'b0);

        // 3^6 mod 256
        do_reset();
        for (int i = 0; i < 6; i++) do_push(i, 0);
        do_backtrack(1, 1'b0);
        chk("pow3_const", int'(result), 217);

        // backtrack on empty
        do_backtrack(1, 1'b0);
        chk("empty_bt_result", int'(result), 1);

        // reset during POP: no final_done, stack cleared
        do_reset();
        do_push(2, 1);
        do_push(4, 0);
        do_push(6, 1);
        backtrack = 1'b1;
        base_val  = 8'd9;
        @(posedge clk);
        #1 backtrack = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        mdl_q.delete();
        mdl_n   = 0;
        mdl_tt  = 0;
        mdl_err = 0;
        @(negedge clk);
        chk("midrst_count", int'(count), 0);
        chk("midrst_ready", int'(ready), 1);
        chk("midrst_result", int'(result), 0);
        repeat (10) @(negedge clk);

        // randomized traffic
        for (int it = 0; it < 30; it++) begin
            int np;
            np = $urandom_range(0, 10);
            for (int j = 0; j < np; j++) begin
                do_push($urandom_range(0, 15), $urandom_range(0, 1));
            end
            check_occupancy("rand");
            do_backtrack($urandom_range(0, 255), ($urandom_range(0, 3) == 0));
        end

        repeat (5) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
